// File: rtl/seek_controller.sv
// -----------------------------------------------------------------------------
// seek_controller
//
// Purpose:
//   Transport front-end for the player. Debounces the raw play, fast-forward
//   and rewind push-buttons and runs a four-state transport FSM
//   (PAUSED / PLAY / FWD / REW) that drives the Timer's count enable and
//   signed step (adder). While a seek button is held, the step magnitude
//   grows in three levels as Timer ticks accumulate.
//
// Configuration:
//   SEEK_AUTOPLAY_EN  when defined, leaving FWD/REW always lands in PLAY;
//                     when undefined, it returns to the state seeking began in.
//
// Ports:
//   i_clk       in   1  system clock, rising edge
//   i_reset     in   1  synchronous, active-low reset
//   i_tick      in   1  one-cycle strobe per Timer step boundary
//   i_play_btn  in   1  raw play/pause button, active-high
//   i_ff_btn    in   1  raw fast-forward button, active-high
//   i_rw_btn    in   1  raw rewind button, active-high
//   o_count     out  1  Timer count enable
//   o_adder     out  9  signed step to Timer adder, two's complement
//   o_state     out  2  transport state: 0 PAUSED, 1 PLAY, 2 FWD, 3 REW
// -----------------------------------------------------------------------------
module seek_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLD1_TICKS     = 3,
    parameter int unsigned HOLD2_TICKS     = 6,
    parameter logic [7:0]  STEP_L0         = 8'd2,
    parameter logic [7:0]  STEP_L1         = 8'd8,
    parameter logic [7:0]  STEP_L2         = 8'd15
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_tick,
    input  logic       i_play_btn,
    input  logic       i_ff_btn,
    input  logic       i_rw_btn,
    output logic       o_count,
    output logic [8:0] o_adder,
    output logic [1:0] o_state
);

    typedef enum logic [1:0] {
        PAUSED = 2'd0,
        PLAY   = 2'd1,
        FWD    = 2'd2,
        REW    = 2'd3
    } state_t;

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLD2_TICKS + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD1    = HW'(HOLD1_TICKS);
    localparam logic [HW-1:0] HOLD2    = HW'(HOLD2_TICKS);

    // Button index: 0 play, 1 ff, 2 rw
    logic [2:0]    w_raw;
    logic [2:0]    r_deb;
    logic [2:0]    w_debNext;
    logic [CW-1:0] r_dbCnt   [3];
    logic [CW-1:0] w_dbCntNext [3];

    state_t        r_state;
    state_t        w_stateNext;
    state_t        r_retState;
    state_t        w_retNext;
    logic [HW-1:0] r_holdCnt;
    logic [HW-1:0] w_holdNext;
    logic          r_count;
    logic          w_countNext;
    logic [8:0]    r_adder;
    logic [8:0]    w_adderNext;

    logic          w_playEdge;
    logic          w_ff;
    logic          w_rw;
    logic [7:0]    w_step;
    logic [8:0]    w_stepExt;

    assign w_raw = {i_rw_btn, i_ff_btn, i_play_btn};

    // Debounce: the FSM looks at the value each debouncer takes on this edge,
    // so a button change acts on the same edge that accepts it.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_debNext[i]   = r_deb[i];
            w_dbCntNext[i] = '0;
            if (w_raw[i] != r_deb[i]) begin
                if (r_dbCnt[i] == CNT_LAST) begin
                    w_debNext[i] = w_raw[i];
                end else begin
                    w_dbCntNext[i] = r_dbCnt[i] + CW'(1);
                end
            end
        end
    end

    assign w_playEdge = w_debNext[0] & ~r_deb[0];
    assign w_ff       = w_debNext[1];
    assign w_rw       = w_debNext[2];

    // Debouncer registers
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_deb <= '0;
            for (int i = 0; i < 3; i++) begin
                r_dbCnt[i] <= '0;
            end
        end else begin
            r_deb <= w_debNext;
            for (int i = 0; i < 3; i++) begin
                r_dbCnt[i] <= w_dbCntNext[i];
            end
        end
    end

    // Transport FSM next state, hold counter and registered outputs.
    // Outputs are derived from the next state so they move on the same edge.
    always_comb begin
        w_stateNext = r_state;
        w_retNext   = r_retState;
        w_holdNext  = r_holdCnt;
        w_step      = STEP_L0;
        w_stepExt   = '0;
        w_countNext = 1'b0;
        w_adderNext = 9'd1;

        case (r_state)
            PAUSED, PLAY: begin
                // Seek takes priority; a simultaneous play edge is dropped.
                if (w_ff && !w_rw) begin
                    w_stateNext = FWD;
                    w_retNext   = r_state;
                    w_holdNext  = '0;
                end else if (w_rw && !w_ff) begin
                    w_stateNext = REW;
                    w_retNext   = r_state;
                    w_holdNext  = '0;
                end else if (!w_ff && !w_rw && w_playEdge) begin
                    w_stateNext = (r_state == PAUSED) ? PLAY : PAUSED;
                end
            end
            FWD, REW: begin
                if ((r_state == FWD && !w_ff) || (r_state == REW && !w_rw)) begin
`ifdef SEEK_AUTOPLAY_EN
                    w_stateNext = PLAY;
`else
                    w_stateNext = r_retState;
`endif
                    w_holdNext  = '0;
                end else if (i_tick && (r_holdCnt < HOLD2)) begin
                    w_holdNext = r_holdCnt + HW'(1);
                end
            end
            default: w_stateNext = PAUSED;
        endcase

        if (w_holdNext >= HOLD2) begin
            w_step = STEP_L2;
        end else if (w_holdNext >= HOLD1) begin
            w_step = STEP_L1;
        end

        w_stepExt = {1'b0, w_step};

        case (w_stateNext)
            PLAY: begin
                w_countNext = 1'b1;
                w_adderNext = 9'd1;
            end
            FWD: begin
                w_countNext = 1'b1;
                w_adderNext = w_stepExt;
            end
            REW: begin
                w_countNext = 1'b1;
                w_adderNext = ~w_stepExt + 9'd1;
            end
            default: begin
                w_countNext = 1'b0;
                w_adderNext = 9'd1;
            end
        endcase
    end

    // State register and registered outputs
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state    <= PAUSED;
            r_retState <= PAUSED;
            r_holdCnt  <= '0;
            r_count    <= 1'b0;
            r_adder    <= 9'd1;
        end else begin
            r_state    <= w_stateNext;
            r_retState <= w_retNext;
            r_holdCnt  <= w_holdNext;
            r_count    <= w_countNext;
            r_adder    <= w_adderNext;
        end
    end

    assign o_count = r_count;
    assign o_adder = r_adder;
    assign o_state = r_state;

endmodule
